// File: rtl/buscaminas_input_ctrl.sv
// Buscaminas (minesweeper) input controller.
// Synchronizes and debounces seven pushbuttons, turns qualified presses into
// single-cycle events, arbitrates them by priority and tracks the board cursor.
module buscaminas_input_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int BOARD_N    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_select,
  input  logic       btn_mark,
  input  logic       btn_start,
  input  logic       game_en,
  output logic       move,
  output logic [1:0] course,
  output logic       select,
  output logic       mark,
  output logic       str,
  output logic [2:0] cur_row,
  output logic [2:0] cur_col
);

  localparam int             NB      = 7;
  localparam int             CNT_W   = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [2:0]     LAST    = 3'(BOARD_N - 1);

  // Button bit order: 6 start, 5 select, 4 mark, 3 up, 2 down, 1 left, 0 right
  logic [NB-1:0]    w_raw;
  logic [NB-1:0]    r_sync_p0;
  logic [NB-1:0]    r_sync_p1;
  logic [CNT_W-1:0] r_cnt [NB];
  logic [NB-1:0]    r_stable;
  logic [NB-1:0]    r_stable_d;
  logic [NB-1:0]    w_rise;

  logic             w_str;
  logic             w_sel;
  logic             w_mark;
  logic             w_move;
  logic [1:0]       w_dir;

  logic             r_move;
  logic             r_sel;
  logic             r_mark;
  logic             r_str;
  logic [1:0]       r_course;
  logic [2:0]       r_row;
  logic [2:0]       r_col;

  // Cursor step with wrap-around on a BOARD_N-wide board
  function automatic logic [2:0] wrap_dec(input logic [2:0] v);
    return (v == 3'd0) ? LAST : v - 3'd1;
  endfunction

  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == LAST) ? 3'd0 : v + 3'd1;
  endfunction

  assign w_raw  = {btn_start, btn_select, btn_mark, btn_up, btn_down, btn_left, btn_right};
  assign w_rise = r_stable & ~r_stable_d;

  // Two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= w_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Debounce: a level change is accepted after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= '0;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (r_sync_p1[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_cnt[i]    <= '0;
          r_stable[i] <= ~r_stable[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Priority arbitration; gameplay events are dropped outright while no game runs
  always_comb begin
    w_str  = 1'b0;
    w_sel  = 1'b0;
    w_mark = 1'b0;
    w_move = 1'b0;
    w_dir  = r_course;
    if (w_rise[6]) begin
      w_str = 1'b1;
    end else if (game_en) begin
      if (w_rise[5]) begin
        w_sel = 1'b1;
      end else if (w_rise[4]) begin
        w_mark = 1'b1;
      end else if (w_rise[3]) begin
        w_move = 1'b1;
        w_dir  = 2'b00;
      end else if (w_rise[2]) begin
        w_move = 1'b1;
        w_dir  = 2'b01;
      end else if (w_rise[1]) begin
        w_move = 1'b1;
        w_dir  = 2'b10;
      end else if (w_rise[0]) begin
        w_move = 1'b1;
        w_dir  = 2'b11;
      end
    end
  end

  // Registered event pulses, direction and cursor position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable_d <= '0;
      r_move     <= 1'b0;
      r_sel      <= 1'b0;
      r_mark     <= 1'b0;
      r_str      <= 1'b0;
      r_course   <= 2'b00;
      r_row      <= 3'd0;
      r_col      <= 3'd0;
    end else begin
      r_stable_d <= r_stable;
      r_move     <= w_move;
      r_sel      <= w_sel;
      r_mark     <= w_mark;
      r_str      <= w_str;
      if (w_str) begin
        r_row <= 3'd0;
        r_col <= 3'd0;
      end else if (w_move) begin
        r_course <= w_dir;
        case (w_dir)
          2'b00:   r_row <= wrap_dec(r_row);
          2'b01:   r_row <= wrap_inc(r_row);
          2'b10:   r_col <= wrap_dec(r_col);
          default: r_col <= wrap_inc(r_col);
        endcase
      end
    end
  end

  assign move    = r_move;
  assign select  = r_sel;
  assign mark    = r_mark;
  assign str     = r_str;
  assign course  = r_course;
  assign cur_row = r_row;
  assign cur_col = r_col;

endmodule

// File: tb/tb_buscaminas_input_ctrl.sv
// Testbench for buscaminas_input_ctrl with DEB_CYCLES=4, BOARD_N=8.
module tb_buscaminas_input_ctrl;

  logic       clk;
  logic       rst;
  logic [6:0] btns;   // 6 start, 5 select, 4 mark, 3 up, 2 down, 1 left, 0 right
  logic       game_en;
  logic       move;
  logic [1:0] course;
  logic       select;
  logic       mark;
  logic       str;
  logic [2:0] cur_row;
  logic [2:0] cur_col;

  int n_cmp;
  int n_err;

  logic [1:0] e_course;
  logic [2:0] e_row;
  logic [2:0] e_col;

  // Observed vector: {str, select, mark, move, course, row, col}
  logic [11:0] obs;
  assign obs = {str, select, mark, move, course, cur_row, cur_col};

  localparam logic [3:0] K_NONE = 4'b0000;
  localparam logic [3:0] K_STR  = 4'b1000;
  localparam logic [3:0] K_SEL  = 4'b0100;
  localparam logic [3:0] K_MARK = 4'b0010;
  localparam logic [3:0] K_MOVE = 4'b0001;

  typedef struct packed {
    logic [6:0] btn;
    logic       en;
    logic [3:0] kind;
    logic [1:0] course;
    logic [2:0] row;
    logic [2:0] col;
  } vec_t;

  vec_t tbl [0:15];

  buscaminas_input_ctrl #(.DEB_CYCLES(4), .BOARD_N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btns[3]),
    .btn_down  (btns[2]),
    .btn_left  (btns[1]),
    .btn_right (btns[0]),
    .btn_select(btns[5]),
    .btn_mark  (btns[4]),
    .btn_start (btns[6]),
    .game_en   (game_en),
    .move      (move),
    .course    (course),
    .select    (select),
    .mark      (mark),
    .str       (str),
    .cur_row   (cur_row),
    .cur_col   (cur_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [11:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h (str/sel/mark/move=%b course=%b row=%0d col=%0d) expected %h",
               nm, obs, obs[11:8], obs[7:6], obs[5:3], obs[2:0], exp);
    end
  endtask

  // One clock, then sample on the falling edge
  task automatic step_chk(input string nm, input logic [3:0] kind);
    @(posedge clk);
    @(negedge clk);
    chk(nm, {kind, e_course, e_row, e_col});
  endtask

  // Press, hold 16 cycles (pulse expected only after the 7th edge), release 10 cycles
  task automatic run_press(input vec_t v, input string nm);
    game_en = v.en;
    btns    = v.btn;
    for (int c = 1; c <= 16; c++) begin
      if (c == 7) begin
        e_course = v.course;
        e_row    = v.row;
        e_col    = v.col;
        step_chk($sformatf("%s_c%0d", nm, c), v.kind);
      end else begin
        step_chk($sformatf("%s_c%0d", nm, c), K_NONE);
      end
    end
    btns = 7'd0;
    for (int c = 1; c <= 10; c++) step_chk($sformatf("%s_rel%0d", nm, c), K_NONE);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    e_course = 2'b00;
    e_row    = 3'd0;
    e_col    = 3'd0;

    //            btn         en    kind    course row   col
    tbl[0]  = '{7'b1000000, 1'b0, K_STR,  2'b00, 3'd0, 3'd0};
    tbl[1]  = '{7'b0001000, 1'b1, K_MOVE, 2'b00, 3'd7, 3'd0};
    tbl[2]  = '{7'b0000001, 1'b1, K_MOVE, 2'b11, 3'd7, 3'd1};
    tbl[3]  = '{7'b0000001, 1'b1, K_MOVE, 2'b11, 3'd7, 3'd2};
    tbl[4]  = '{7'b0000001, 1'b1, K_MOVE, 2'b11, 3'd7, 3'd3};
    tbl[5]  = '{7'b0000001, 1'b1, K_MOVE, 2'b11, 3'd7, 3'd4};
    tbl[6]  = '{7'b0010010, 1'b1, K_MARK, 2'b11, 3'd7, 3'd4};
    tbl[7]  = '{7'b0000100, 1'b0, K_NONE, 2'b11, 3'd7, 3'd4};
    tbl[8]  = '{7'b0000100, 1'b1, K_MOVE, 2'b01, 3'd0, 3'd4};
    tbl[9]  = '{7'b0000010, 1'b1, K_MOVE, 2'b10, 3'd0, 3'd3};
    tbl[10] = '{7'b1101000, 1'b1, K_STR,  2'b10, 3'd0, 3'd0};
    tbl[11] = '{7'b0000010, 1'b1, K_MOVE, 2'b10, 3'd0, 3'd7};
    tbl[12] = '{7'b0000001, 1'b1, K_MOVE, 2'b11, 3'd0, 3'd0};
    tbl[13] = '{7'b0110000, 1'b1, K_SEL,  2'b11, 3'd0, 3'd0};
    tbl[14] = '{7'b0001100, 1'b1, K_MOVE, 2'b00, 3'd7, 3'd0};
    tbl[15] = '{7'b0000111, 1'b1, K_MOVE, 2'b01, 3'd0, 3'd0};

    // Reset state, idle and with every button held
    rst     = 1'b1;
    btns    = 7'd0;
    game_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_idle", 12'h000);
    btns = 7'h7F;
    game_en = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("reset_held", 12'h000);
    btns    = 7'd0;
    game_en = 1'b0;
    rst     = 1'b0;
    for (int c = 0; c < 4; c++) step_chk("post_reset", K_NONE);

    // Directed press table
    for (int i = 0; i < 16; i++) run_press(tbl[i], $sformatf("vec%0d", i));

    // Bouncing select: 20 cycles of 2-high/2-low, then held high
    game_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      btns[5] = 1'b1;
      step_chk("bounce_hi", K_NONE);
      step_chk("bounce_hi", K_NONE);
      btns[5] = 1'b0;
      step_chk("bounce_lo", K_NONE);
      step_chk("bounce_lo", K_NONE);
    end
    btns[5] = 1'b1;
    for (int c = 1; c <= 16; c++)
      step_chk($sformatf("bounce_hold_c%0d", c), (c == 7) ? K_SEL : K_NONE);
    btns = 7'd0;
    for (int c = 1; c <= 10; c++) step_chk("bounce_rel", K_NONE);

    // Direction press with game_en=0 is discarded
    game_en = 1'b0;
    btns[2] = 1'b1;
    for (int c = 1; c <= 12; c++) step_chk("noen_down", K_NONE);
    btns = 7'd0;
    for (int c = 1; c <= 10; c++) step_chk("noen_rel", K_NONE);

    // Reset three cycles into a start qualification, button released during reset
    btns[6] = 1'b1;
    for (int c = 1; c <= 3; c++) step_chk("abort_pre", K_NONE);
    rst  = 1'b1;
    btns = 7'd0;
    e_course = 2'b00;
    e_row    = 3'd0;
    e_col    = 3'd0;
    #1;
    chk("abort_in_reset", 12'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) step_chk("abort_post", K_NONE);

    // Start held through reset: one pulse after a full qualification from release
    btns[6] = 1'b1;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("held_in_reset", 12'h000);
    rst = 1'b0;
    for (int c = 1; c <= 16; c++)
      step_chk($sformatf("held_rst_c%0d", c), (c == 7) ? K_STR : K_NONE);
    btns = 7'd0;
    for (int c = 1; c <= 10; c++) step_chk("held_rst_rel", K_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
